// File: rtl/arcade_osd_triggers.sv
// OSD trigger pulse stretcher and core reset sequencer for MiST arcade tops.
// Edges on OSD status bits become fixed-length pulses; reset sources merge into one held core reset.
module arcade_osd_triggers #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PULSE_W   = 20,
    parameter int unsigned PULSE_LEN = 20'hFFFFF,
    parameter int unsigned RST_SRCS  = 4,
    parameter int unsigned RST_W     = 16,
    parameter int unsigned RST_HOLD  = 1024
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trig_in,
    input  logic [CHANNELS-1:0] retrig,
    input  logic                pause,
    input  logic [RST_SRCS-1:0] rst_src,
    output logic [CHANNELS-1:0] trig_out,
    output logic                busy,
    output logic                rst_out,
    output logic                rst_done
);

    localparam logic [PULSE_W-1:0] LP_PULSE_LEN = PULSE_W'(PULSE_LEN);
    localparam logic [RST_W-1:0]   LP_RST_HOLD  = RST_W'(RST_HOLD);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_IDLE
    } rst_state_t;

    logic [CHANNELS-1:0]              r_trig_q;
    logic [CHANNELS-1:0][PULSE_W-1:0] r_cnt;
    logic [CHANNELS-1:0]              r_trig_out;
    logic                             r_busy;

    logic [CHANNELS-1:0]              w_edge;
    logic [CHANNELS-1:0][PULSE_W-1:0] w_cnt_nxt;
    logic [CHANNELS-1:0]              w_active;

    rst_state_t       r_state;
    rst_state_t       w_state_nxt;
    logic [RST_W-1:0] r_hold;
    logic [RST_W-1:0] w_hold_nxt;
    logic             r_rst_out;
    logic             w_rst_nxt;
    logic             r_rst_done;

    assign w_edge = trig_in & ~r_trig_q;

    // An edge on a busy one-shot channel falls through to the plain decrement.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_active  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_active[i] = (r_cnt[i] != '0);
            if (!pause) begin
                if (w_edge[i] && (!w_active[i] || retrig[i])) begin
                    w_cnt_nxt[i] = LP_PULSE_LEN;
                end else if (w_active[i]) begin
                    w_cnt_nxt[i] = r_cnt[i] - PULSE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        r_trig_q <= trig_in;
        if (reset) begin
            r_cnt      <= '0;
            r_trig_out <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_trig_out <= w_active;
            r_busy     <= |w_active;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_rst_nxt   = r_rst_out;
        if (|rst_src) begin
            w_state_nxt = ST_ASSERT;
            w_hold_nxt  = LP_RST_HOLD;
            w_rst_nxt   = 1'b1;
        end else begin
            case (r_state)
                ST_ASSERT, ST_HOLD: begin
                    if (r_hold != '0) begin
                        w_state_nxt = ST_HOLD;
                        w_hold_nxt  = r_hold - RST_W'(1);
                        w_rst_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_rst_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                    w_rst_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= ST_HOLD;
            r_hold     <= LP_RST_HOLD;
            r_rst_out  <= 1'b1;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_rst_out  <= w_rst_nxt;
            r_rst_done <= r_rst_out & ~w_rst_nxt;
        end
    end

    assign trig_out = r_trig_out;
    assign busy     = r_busy;
    assign rst_out  = r_rst_out;
    assign rst_done = r_rst_done;

endmodule

// File: tb/tb_arcade_osd_triggers.sv
// Directed self-checking bench for arcade_osd_triggers (PULSE_LEN=8, RST_HOLD=4).
module tb_arcade_osd_triggers;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [3:0] trig_in;
    logic [3:0] retrig;
    logic       pause;
    logic [3:0] rst_src;
    logic [3:0] trig_out;
    logic       busy;
    logic       rst_out;
    logic       rst_done;

    int n_run  = 0;
    int n_fail = 0;
    int hc     = 0;
    int bc     = 0;
    int bmis   = 0;
    int first  = -1;
    int dc     = 0;

    arcade_osd_triggers #(
        .CHANNELS (4),
        .PULSE_W  (8),
        .PULSE_LEN(8),
        .RST_SRCS (4),
        .RST_W    (8),
        .RST_HOLD (4)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .trig_in (trig_in),
        .retrig  (retrig),
        .pause   (pause),
        .rst_src (rst_src),
        .trig_out(trig_out),
        .busy    (busy),
        .rst_out (rst_out),
        .rst_done(rst_done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input int obs, input int exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One clock, then tally the sampled state of channel ch.
    task automatic acc(input int ch, input int idx);
        tick();
        if (trig_out[ch]) begin
            hc++;
            if (first < 0) first = idx;
        end
        if (busy) bc++;
        if (busy !== (|trig_out)) bmis++;
    endtask

    task automatic clr();
        hc = 0; bc = 0; bmis = 0; first = -1;
    endtask

    initial begin
        reset   = 1'b1;
        trig_in = 4'b0010;
        retrig  = 4'b0000;
        pause   = 1'b0;
        rst_src = 4'b0000;
        tick();
        tick();
        chk("reset_trig_out", int'(trig_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rst_out", int'(rst_out), 1);
        chk("reset_rst_done", int'(rst_done), 0);

        // Power-on stretch; trig_in[1] high across release must stay silent.
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("por_rst_out_high", int'(rst_out), 1);
            chk("por_held_input_no_pulse", int'(trig_out), 0);
        end
        tick();
        chk("por_rst_out_low", int'(rst_out), 0);
        chk("por_rst_done_pulse", int'(rst_done), 1);
        tick();
        chk("por_rst_done_single", int'(rst_done), 0);
        chk("por_still_no_pulse", int'(trig_out), 0);

        // Basic 8-cycle pulse on channel 0.
        trig_in[0] = 1'b1;
        tick();
        chk("ch0_not_yet_at_E0", int'(trig_out[0]), 0);
        clr();
        for (int k = 0; k < 12; k++) acc(0, k);
        chk("ch0_pulse_len", hc, 8);
        chk("ch0_pulse_start", first, 0);
        chk("ch0_busy_len", bc, 8);
        chk("ch0_busy_align", bmis, 0);

        // Channel 1: low then high gives one pulse.
        trig_in[1] = 1'b0;
        tick();
        trig_in[1] = 1'b1;
        tick();
        clr();
        for (int k = 0; k < 12; k++) acc(1, k);
        chk("ch1_pulse_len", hc, 8);
        chk("ch1_pulse_start", first, 0);

        // One-shot channel 2: second edge at E3 is ignored.
        clr();
        trig_in[2] = 1'b1;
        tick();
        acc(2, 0);
        trig_in[2] = 1'b0;
        acc(2, 1);
        trig_in[2] = 1'b1;
        acc(2, 2);
        for (int k = 3; k < 18; k++) acc(2, k);
        chk("oneshot_len", hc, 8);

        // Retriggerable channel 3: same stimulus gives 11 cycles.
        retrig = 4'b1000;
        clr();
        trig_in[3] = 1'b1;
        tick();
        acc(3, 0);
        trig_in[3] = 1'b0;
        acc(3, 1);
        trig_in[3] = 1'b1;
        acc(3, 2);
        for (int k = 3; k < 18; k++) acc(3, k);
        chk("retrig_len", hc, 11);
        chk("retrig_busy_align", bmis, 0);

        // Pause 5 cycles mid-pulse on retriggerable ch0; edge inside pause is dropped.
        retrig = 4'b1001;
        trig_in[0] = 1'b0;
        tick();
        trig_in[0] = 1'b1;
        tick();
        clr();
        acc(0, 0);
        acc(0, 1);
        pause = 1'b1;
        trig_in[0] = 1'b0;
        acc(0, 2);
        acc(0, 3);
        trig_in[0] = 1'b1;
        acc(0, 4);
        acc(0, 5);
        acc(0, 6);
        pause = 1'b0;
        for (int k = 7; k < 24; k++) acc(0, k);
        chk("pause_len", hc, 13);

        // Edge during pause on idle ch1 must not fire after release.
        pause = 1'b1;
        trig_in[1] = 1'b0;
        tick();
        trig_in[1] = 1'b1;
        tick();
        pause = 1'b0;
        clr();
        for (int k = 0; k < 12; k++) acc(1, k);
        chk("pause_edge_dropped", hc, 0);
        chk("pause_busy_idle", int'(busy), 0);

        // rst_src[2] for 10 cycles, then HOLD of 4.
        chk("seq_idle_before", int'(rst_out), 0);
        rst_src = 4'b0100;
        tick();
        chk("src_latency", int'(rst_out), 1);
        for (int k = 1; k < 10; k++) tick();
        rst_src = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_rst_out_high", int'(rst_out), 1);
            chk("hold_no_done", int'(rst_done), 0);
        end
        tick();
        chk("hold_release_low", int'(rst_out), 0);
        chk("hold_release_done", int'(rst_done), 1);
        tick();
        chk("hold_done_single", int'(rst_done), 0);

        // Source re-asserted during HOLD restarts the full count.
        rst_src = 4'b0100;
        tick();
        tick();
        rst_src = 4'b0000;
        tick();
        tick();
        rst_src = 4'b0001;
        tick();
        chk("restart_assert", int'(rst_out), 1);
        rst_src = 4'b0000;
        dc = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("restart_rst_out", int'(rst_out), (k < 4) ? 1 : 0);
            if (rst_done) dc++;
            if (k == 4) chk("restart_done_at_release", int'(rst_done), 1);
        end
        chk("restart_done_count", dc, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
